mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_array.sv | 31 +++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, access size codes
// and the request classification helper.
package mem_responder_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] size_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam size_t SIZE_B = 2'b00;
  localparam size_t SIZE_H = 2'b01;
  localparam size_t SIZE_W = 2'b10;

  // A request is rejected for an illegal size, a misaligned half/word, or a word index
  // beyond the array.
  function automatic logic req_is_err(input size_t size, input logic [31:0] addr,
                                      input int unsigned depth);
    logic bad_align;
    case (size)
      SIZE_B:  bad_align = 1'b0;
      SIZE_H:  bad_align = addr[0];
      SIZE_W:  bad_align = |addr[1:0];
      default: bad_align = 1'b1;
    endcase
    return bad_align || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  size_t       req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x 32 storage with byte-enabled synchronous write and synchronous read.
// Contents are never reset; the read register only updates when a read is requested.
module mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store, inserts WAIT_CYCLES wait
// states, performs the access, then holds the response until the requester takes it.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // Counter runs WAIT_CYCLES-1 down to 0, leaving WAIT on the zero cycle.
  localparam logic [CntW-1:0] CntLoad = CntW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  size_t           size_q;
  logic            uns_q;
  logic            err_q;

  logic            accept;
  logic            req_err;
  logic            mem_we;
  logic            mem_re;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic [15:0]     lane_word;
  logic [31:0]     load_data;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign req_err = req_is_err(bus.req_size, bus.req_addr, DEPTH);

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = CntLoad;
          if (req_err)              state_d = ST_RESP;
          else if (WAIT_CYCLES > 0) state_d = ST_WAIT;
          else                      state_d = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, counter and latched request fields with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr[AW+1:0];
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_err;
      end
    end
  end

  // Store lane steering: replicate the right-aligned data and enable only the target lanes.
  always_comb begin
    case (size_q)
      SIZE_B: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      SIZE_H: begin
        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
      end
    endcase
  end

  // Reset gates the write so an aborted store never lands.
  assign mem_we = (state_q == ST_ACCESS) && we_q && reset;
  assign mem_re = (state_q == ST_ACCESS) && !we_q;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .be_i    (mem_be),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Load lane selection and zero/sign extension.
  always_comb begin
    lane_word = 16'(mem_rdata >> {addr_q[1:0], 3'b000});
    case (size_q)
      SIZE_B:  load_data = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
      SIZE_H:  load_data = {{16{~uns_q & lane_word[15]}}, lane_word[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written reset/backpressure
// sequences and random traffic checked against a byte-addressed reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAIT  = 2;

  logic clk;
  logic reset;

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference memory kept as individual bytes, little-endian.
  logic [7:0] mbytes [DEPTH*4];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, output logic err, output logic [31:0] rdata);
    int unsigned     nb;
    longint unsigned val;
    nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err   = (size == 2'b11) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(nb); i++) mbytes[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < int'(nb); i++) val += longint'(mbytes[int'(addr) + i]) << (8 * i);
      if (!uns && nb < 4 && val >= (64'd1 << (8 * nb - 1))) val = val - (64'd1 << (8 * nb));
      rdata = val[31:0];
    end
  endfunction

  // One full transaction; the request inputs are scrambled right after acceptance and a
  // competing request is presented during the response handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int hold,
                     input string tag, output logic err, output logic [31:0] rdata,
                     output int lat);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    chk({tag, " req_ready idle"}, {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = ~size;
    bus.req_unsigned = ~uns;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: rsp_valid 0 after %0d cycles, required 1", tag, lat);
      err   = 1'bx;
      rdata = 'x;
      return;
    end
    err   = bus.rsp_err;
    rdata = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold flags"}, {29'b0, bus.rsp_valid, bus.rsp_err, bus.req_ready},
          {29'b0, 1'b1, err, 1'b0});
      chk({tag, " hold rdata"}, bus.rsp_rdata, rdata);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = SIZE_W;
    bus.req_addr  = 32'h0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, " after handshake ready/valid"}, {30'b0, bus.req_ready, bus.rsp_valid},
        32'b10);
    bus.req_valid = 1'b0;
  endtask

  // Transaction checked against the reference model.
  task automatic run_model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input int hold,
                           input string tag);
    logic        e_err, g_err;
    logic [31:0] e_rd, g_rd;
    int          lat;
    model(we, addr, wdata, size, uns, e_err, e_rd);
    txn(we, addr, wdata, size, uns, hold, tag, g_err, g_rd, lat);
    chk({tag, " err"}, {31'b0, g_err}, {31'b0, e_err});
    chk({tag, " rdata"}, g_rd, e_rd);
    chk({tag, " latency"}, lat, e_err ? 32'd1 : WAIT + 2);
  endtask

  task automatic expect_no_rsp(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      seen |= bus.rsp_valid;
    end
    chk({tag, " no response"}, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    logic        g_err, e_err;
    logic [31:0] g_rd, e_rd;
    int          lat;
    logic [31:0] a;
    int          r;

    n_tests = 0;
    n_fail  = 0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = SIZE_B;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;
    reset            = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {bus.rsp_rdata[29:0], bus.req_ready, bus.rsp_valid},
        {30'b0, 1'b1, 1'b0});
    chk("reset err", {31'b0, bus.rsp_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post-reset ready", {31'b0, bus.req_ready}, 32'd1);

    //              we    addr          wdata         size    uns   err   rdata
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, SIZE_W, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, SIZE_W, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         SIZE_W, 1'b0, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         SIZE_B, 1'b0, 1'b0, 32'hFFFF_FFDE});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         SIZE_B, 1'b1, 1'b0, 32'h0000_00DE});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         SIZE_H, 1'b0, 1'b0, 32'hFFFF_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         SIZE_H, 1'b1, 1'b0, 32'h0000_DEAD});
    vecs.push_back('{1'b1, 32'h0000_0011, 32'h1234_5655, SIZE_B, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         SIZE_W, 1'b0, 1'b0, 32'hDEAD_55EF});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         SIZE_W, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b11,  1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0011, 32'h0,         SIZE_H, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h1234_5678, SIZE_W, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         SIZE_W, 1'b0, 1'b0, 32'hCAFE_F00D});
    vecs.push_back('{1'b1, 32'h0000_0014, 32'h1122_3344, SIZE_W, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0016, 32'hFFFF_ABCD, SIZE_H, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         SIZE_W, 1'b0, 1'b0, 32'hABCD_3344});
    vecs.push_back('{1'b0, 32'h0000_0016, 32'h0,         SIZE_H, 1'b0, 1'b0, 32'hFFFF_ABCD});
    vecs.push_back('{1'b0, 32'h0000_0015, 32'h0,         SIZE_B, 1'b0, 1'b0, 32'h0000_0033});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, SIZE_W, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_03FF, 32'h0,         SIZE_B, 1'b1, 1'b0, 32'h0000_000B});
    vecs.push_back('{1'b0, 32'h0000_03FD, 32'h0,         SIZE_H, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         SIZE_W, 1'b0, 1'b1, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, e_err, e_rd);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, 0, tag,
          g_err, g_rd, lat);
      chk({tag, " err"}, {31'b0, g_err}, {31'b0, vecs[i].exp_err});
      chk({tag, " rdata"}, g_rd, vecs[i].exp_rdata);
      chk({tag, " latency"}, lat, vecs[i].exp_err ? 32'd1 : WAIT + 2);
    end

    // Backpressure: response held for five cycles
    run_model(1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 5, "hold5");
    run_model(1'b0, 32'h12, 32'h0, SIZE_W, 1'b0, 5, "hold5 err");

    // Reset during WAIT of a store aborts it
    run_model(1'b1, 32'h20, 32'h1357_2468, SIZE_W, 1'b0, 0, "pre wait-abort");
    bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h7777_7777;
    bus.req_size = SIZE_W; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("wait-abort valid in reset", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("wait-abort ready", {30'b0, bus.req_ready, bus.rsp_valid}, 32'b10);
    expect_no_rsp("wait-abort", 6);
    run_model(1'b0, 32'h20, 32'h0, SIZE_W, 1'b0, 0, "wait-abort readback");

    // Reset during ACCESS of a store: the write must be suppressed
    run_model(1'b1, 32'h24, 32'h2468_ACE0, SIZE_W, 1'b0, 0, "pre access-abort");
    bus.req_we = 1'b1; bus.req_addr = 32'h24; bus.req_wdata = 32'h5A5A_5A5A;
    bus.req_size = SIZE_W; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (WAIT) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("access-abort ready", {30'b0, bus.req_ready, bus.rsp_valid}, 32'b10);
    expect_no_rsp("access-abort", 6);
    run_model(1'b0, 32'h24, 32'h0, SIZE_W, 1'b0, 0, "access-abort readback");

    // Known contents for the random region
    for (int w = 0; w < 16; w++) run_model(1'b1, 32'(w * 4), $urandom, SIZE_W, 1'b0, 0, "fill");
    for (int w = 252; w < 256; w++) run_model(1'b1, 32'(w * 4), $urandom, SIZE_W, 1'b0, 0, "fill");

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 63));
      else if (r < 9) a = 32'h3F0 + 32'($urandom_range(0, 23));
      else            a = $urandom;
      run_model(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished",
             $time);
    $fatal(1, "watchdog expired");
  end

endmodule
